// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// The optional checksum stage is controlled by the LOADER_CHECKSUM_EN macro.
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;

   // IDLE -> RECV -> WRITE -> {RECV | CHK | DONE} -> IDLE
   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      CHK,
      DONE
   } state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects bytes into a little-endian word: the first byte pushed lands in bits [7:0].
// word_o shows the word including a byte pushed this cycle, and word_full_o flags
// the push that completes the word. The byte index wraps by itself after the last lane,
// so back-to-back words need no explicit clear.
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              clear_i,
   input  logic [7:0]        data_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_full_o
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] lanes_q, lanes_d;
   logic [WORD_W-1:0] merged;

   // Merge the incoming byte into its lane and advance the byte index.
   always_comb begin
      merged     = lanes_q;
      byte_idx_d = byte_idx_q;
      if (push_i) begin
         merged[{byte_idx_q, 3'b000} +: 8] = data_i;
         byte_idx_d = byte_idx_q + IDX_W'(1);
      end
      lanes_d = merged;
      if (clear_i) begin
         lanes_d    = '0;
         byte_idx_d = '0;
      end
      word_o      = merged;
      word_full_o = push_i && (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));
   end

   // Lane and index registers; reset discards any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         lanes_q    <= '0;
         byte_idx_q <= '0;
      end else begin
         lanes_q    <= lanes_d;
         byte_idx_q <= byte_idx_d;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: assembles a byte stream into 32-bit words
// and writes them from address 0 upward while holding the core off.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing 4-byte checksum (mod 2^32 sum
// of the written words) checked in CHK; a mismatch sets the sticky err output.
// Handshake: a byte moves on any rising edge where in_valid && in_ready; in_ready
// depends only on the current state, never on in_valid.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = 128
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   num_words,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   output logic [WORD_W-1:0]        wr_din,
   output logic                     busy,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     err
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   state_e            state_q, state_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [AW-1:0]     word_idx_q, word_idx_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0] wr_din_q, wr_din_d;
   logic              xfer, asm_clear, asm_full, last_word;
   logic [WORD_W-1:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q, sum_d;
   logic              err_q, err_d;
`endif

   // in_ready comes straight from state so the byte path has no combinational loop.
   assign in_ready  = (state_q == RECV) || (state_q == CHK);
   assign xfer      = in_valid && in_ready;
   assign asm_clear = (state_q == IDLE) && start;
   assign last_word = ({1'b0, word_idx_q} == (cnt_q - (AW+1)'(1)));
   assign busy      = (state_q != IDLE);
   assign cpu_hold  = busy;
   assign wr_addr   = wr_addr_q;
   assign wr_din    = wr_din_q;
`ifdef LOADER_CHECKSUM_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

   byte_word_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .push_i      (xfer),
      .clear_i     (asm_clear),
      .data_i      (in_data),
      .word_o      (asm_word),
      .word_full_o (asm_full)
   );

   // Next-state, counter updates and the write/done strobes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_idx_d = word_idx_q;
      wr_addr_d  = wr_addr_q;
      wr_din_d   = wr_din_q;
      wr_en      = 1'b0;
      done       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               // Saturate so the address never wraps past DEPTH-1.
               cnt_d      = (num_words > CNT_MAX) ? CNT_MAX : num_words;
               word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d      = '0;
               err_d      = 1'b0;
               state_d    = (num_words == '0) ? CHK : RECV;
`else
               state_d    = (num_words == '0) ? DONE : RECV;
`endif
            end
         end
         RECV: begin
            if (asm_full) begin
               wr_addr_d = word_idx_q;
               wr_din_d  = asm_word;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            wr_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d = sum_q + wr_din_q;
`endif
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end else begin
               word_idx_d = word_idx_q + AW'(1);
               state_d    = RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (asm_full) begin
               if (asm_word != sum_q) err_d = 1'b1;
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and write-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         word_idx_q <= '0;
         wr_addr_q  <= '0;
         wr_din_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_idx_q <= word_idx_d;
         wr_addr_q  <= wr_addr_d;
         wr_din_q   <= wr_din_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         err_q      <= err_d;
`endif
      end
   end

endmodule
